// File: rtl/mc_initiator.sv
// mc_initiator
// Host-side initiator for the mc_dut memory controller. Accepts single-beat
// writes and incrementing read bursts on a valid/ready request channel,
// drives them onto the controller pins one access at a time, and returns one
// response per beat on a valid/ready response channel.
//
// Ports:
//   clk, reset        clock (posedge) and asynchronous active-low reset
//   req_valid/ready   command handshake; req_ready only high when idle
//   req_wr            1 = write, 0 = read
//   req_addr          start address
//   req_wdata         write data (reads ignore it)
//   req_len           read beats minus one (writes ignore it)
//   rsp_valid/ready   response beat handshake
//   rsp_rdata         read data, 0 on write responses
//   rsp_err           controller slv_error sampled for this beat
//   rsp_last          final beat of the command
//   mc_en, mc_w_r     controller enable and write/read select
//   mc_addr, mc_wdata controller address and write data
//   mc_rdata          controller read data
//   mc_slv_error      controller error flag
module mc_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_last,
  output logic                  mc_en,
  output logic                  mc_w_r,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0] mc_wdata,
  input  logic [DATA_WIDTH-1:0] mc_rdata,
  input  logic                  mc_slv_error
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RSP,
    RD_ISSUE,
    RD_WAIT,
    RD_RSP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  mc_en_q, mc_en_d;
  logic                  mc_w_r_q, mc_w_r_d;
  logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
  logic [DATA_WIDTH-1:0] mc_wdata_q, mc_wdata_d;

  // All outputs are registered: the next-cycle value of every pin is decided
  // here alongside the next state, so mc_en is high exactly for the cycle the
  // FSM spends in WR or RD_ISSUE.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;
    mc_en_d     = 1'b0;
    mc_w_r_d    = 1'b0;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr;
          cnt_d     = req_len;
          mc_en_d   = 1'b1;
          mc_addr_d = req_addr;
          if (req_wr) begin
            state_d    = WR;
            mc_w_r_d   = 1'b1;
            mc_wdata_d = req_wdata;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      WR: begin
        // The controller reports slv_error for the write on this edge.
        state_d     = WR_RSP;
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = mc_slv_error;
      end
      WR_RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // mc_dut registered data_out on the previous edge; capture it now.
        state_d     = RD_RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mc_rdata;
        rsp_err_d   = mc_slv_error;
        rsp_last_d  = (cnt_q == '0);
      end
      RD_RSP: begin
        // The next beat is only issued once this one is taken, so a stalled
        // host can never cause read data to be overwritten.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (cnt_q != '0) begin
            state_d   = RD_ISSUE;
            cnt_d     = cnt_q - 1'b1;
            addr_d    = addr_q + 1'b1;
            mc_en_d   = 1'b1;
            mc_addr_d = addr_q + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      mc_en_q     <= 1'b0;
      mc_w_r_q    <= 1'b0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      mc_en_q     <= mc_en_d;
      mc_w_r_q    <= mc_w_r_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_last  = rsp_last_q;
  assign mc_en     = mc_en_q;
  assign mc_w_r    = mc_w_r_q;
  assign mc_addr   = mc_addr_q;
  assign mc_wdata  = mc_wdata_q;

endmodule

// File: tb/tb_mc_initiator.sv
// tb_mc_initiator
// Self-checking bench for mc_initiator. A small stand-in for mc_dut sits on
// the controller pins; a command-level reference memory predicts every
// response beat and every controller access.
module tb_mc_initiator;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [LW-1:0] req_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_last;
  logic          mc_en;
  logic          mc_w_r;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_wdata;
  logic [DW-1:0] mc_rdata = '0;
  logic          mc_slv_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_initiator #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_last    (rsp_last),
    .mc_en       (mc_en),
    .mc_w_r      (mc_w_r),
    .mc_addr     (mc_addr),
    .mc_wdata    (mc_wdata),
    .mc_rdata    (mc_rdata),
    .mc_slv_error(mc_slv_error)
  );

  // Controller stand-in: writes land and read data is registered on the edge
  // that sees en high; slv_error follows a per-address table.
  logic [DW-1:0] dut_mem [256] = '{default: 8'h00};
  logic [AW-1:0] last_addr = '0;
  logic          err_tbl [256];

  always @(posedge clk) begin
    if (mc_en && mc_w_r) dut_mem[mc_addr] <= mc_wdata;
    if (mc_en && !mc_w_r) mc_rdata <= dut_mem[mc_addr];
    if (mc_en) last_addr <= mc_addr;
  end

  assign mc_slv_error = mc_en ? err_tbl[mc_addr] : err_tbl[last_addr];

  // Log every controller access and any cycle where a pending response
  // coexists with a new access or with req_ready.
  logic [16:0] acc_q [$];
  int          viol_count = 0;

  always @(negedge clk) begin
    if (mc_en) acc_q.push_back({mc_w_r, mc_addr, mc_wdata});
    if (rsp_valid && (mc_en || req_ready)) viol_count++;
  end

  // Reference model state and per-command expectations.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_data_q [$];
  logic          exp_err_q [$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [LW-1:0] len;
    int            stall;
    logic [31:0]   exp_data;
    logic [3:0]    exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic buildExpected(input logic wr, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len);
    logic [AW-1:0] a;
    exp_data_q.delete();
    exp_err_q.delete();
    if (wr) begin
      exp_data_q.push_back('0);
      exp_err_q.push_back(err_tbl[addr]);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + AW'(i);
        exp_data_q.push_back(ref_mem[a]);
        exp_err_q.push_back(err_tbl[a]);
      end
    end
  endtask

  // Runs one command end to end against exp_data_q/exp_err_q. stall is the
  // number of cycles rsp_ready stays low once each beat is offered.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [LW-1:0] len,
                               input int stall, input string name);
    int n, t, prev_n, start_idx, nbeats, viol0;
    logic [16:0] got, want;
    nbeats    = wr ? 1 : int'(len) + 1;
    start_idx = acc_q.size();
    viol0     = viol_count;
    prev_n    = 0;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    checkOutput({name, " req_ready"}, 32'(req_ready), 32'd1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_len   = len;
    @(negedge clk);
    n = 1;
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_len   = ~len;
    if (wr) ref_mem[addr] = wdata;
    for (int b = 0; b < nbeats; b++) begin
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); n++; t++; end
      checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      if (!rsp_valid) return;
      if (b == 0) checkOutput({name, " latency"}, 32'(n - 1), wr ? 32'd1 : 32'd2);
      else if (stall == 0) checkOutput({name, " spacing"}, 32'(n - prev_n), 32'd3);
      checkOutput($sformatf("%s beat%0d rdata", name, b), 32'(rsp_rdata), 32'(exp_data_q[b]));
      checkOutput($sformatf("%s beat%0d err", name, b), 32'(rsp_err), 32'(exp_err_q[b]));
      checkOutput($sformatf("%s beat%0d last", name, b), 32'(rsp_last),
                  (b == nbeats - 1) ? 32'd1 : 32'd0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        n++;
        checkOutput($sformatf("%s beat%0d hold", name, b),
                    {20'd0, rsp_valid, mc_en, rsp_last, rsp_err, rsp_rdata},
                    {20'd0, 1'b1, 1'b0, (b == nbeats - 1) ? 1'b1 : 1'b0,
                     exp_err_q[b], exp_data_q[b]});
      end
      rsp_ready = 1'b1;
      prev_n = n;
      @(negedge clk);
      n++;
      rsp_ready = 1'b0;
    end
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); n++; t++; end
    checkOutput({name, " idle"}, 32'(req_ready), 32'd1);
    if (stall == 0)
      checkOutput({name, " total"}, 32'(n - 1), wr ? 32'd2 : 32'(3 * nbeats));
    checkOutput({name, " access count"}, 32'(acc_q.size() - start_idx), 32'(nbeats));
    for (int b = 0; b < nbeats && start_idx + b < acc_q.size(); b++) begin
      got  = acc_q[start_idx + b];
      want = wr ? {1'b1, addr, wdata} : {1'b0, addr + AW'(b), 8'h00};
      if (!wr) got[7:0] = 8'h00;
      checkOutput($sformatf("%s access%0d", name, b), 32'(got), 32'(want));
    end
    checkOutput({name, " protocol"}, 32'(viol_count - viol0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [LW-1:0] len;
    int            stall;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      err_tbl[i] = 1'b0;
    end

    vecs[0]  = '{1'b1, 8'h10, 8'hA5, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[1]  = '{1'b0, 8'h10, 8'h5A, 4'd0, 0, 32'h000000A5, 4'b0000};
    vecs[2]  = '{1'b1, 8'hFE, 8'h11, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[3]  = '{1'b1, 8'hFF, 8'h22, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[4]  = '{1'b1, 8'h00, 8'h33, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[5]  = '{1'b0, 8'hFE, 8'h00, 4'd2, 0, 32'h00332211, 4'b0000};
    vecs[6]  = '{1'b1, 8'h40, 8'h01, 4'd0, 1, 32'h00000000, 4'b0000};
    vecs[7]  = '{1'b1, 8'h41, 8'h02, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[8]  = '{1'b1, 8'h42, 8'h03, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[9]  = '{1'b1, 8'h43, 8'h04, 4'd0, 0, 32'h00000000, 4'b0000};
    vecs[10] = '{1'b0, 8'h40, 8'h00, 4'd3, 5, 32'h04030201, 4'b0000};

    // Reset values while reset is held low.
    #12;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp", {28'd0, rsp_valid, rsp_err, rsp_last, 1'b0}, 32'd0);
    checkOutput("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset mc ctl", {30'd0, mc_en, mc_w_r}, 32'd0);
    checkOutput("reset mc bus", {16'd0, mc_addr, mc_wdata}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      exp_data_q.delete();
      exp_err_q.delete();
      for (int b = 0; b < (vecs[i].wr ? 1 : int'(vecs[i].len) + 1); b++) begin
        exp_data_q.push_back(vecs[i].exp_data[8*b +: 8]);
        exp_err_q.push_back(vecs[i].exp_err[b]);
      end
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].len,
                    vecs[i].stall, $sformatf("vec%0d", i));
    end

    // Error sampling on one read beat and on a write.
    err_tbl[8'h41] = 1'b1;
    exp_data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_err_q  = '{1'b0, 1'b1, 1'b0, 1'b0};
    applyStimulus(1'b0, 8'h40, 8'h00, 4'd3, 0, "err_rd");
    err_tbl[8'h41] = 1'b0;
    err_tbl[8'h10] = 1'b1;
    buildExpected(1'b1, 8'h10, 4'd0);
    applyStimulus(1'b1, 8'h10, 8'h5A, 4'd0, 0, "err_wr");
    err_tbl[8'h10] = 1'b0;

    // Full 16-beat burst wrapping through 0xFF.
    buildExpected(1'b0, 8'hF8, 4'd15);
    applyStimulus(1'b0, 8'hF8, 8'h00, 4'd15, 0, "burst16");

    // Randomized commands against the reference model.
    for (int i = 0; i < 256; i++) err_tbl[i] = ($urandom_range(0, 7) == 0);
    for (int k = 0; k < 24; k++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 8'($urandom);
      wdata = 8'($urandom);
      len   = 4'($urandom_range(0, 4));
      stall = $urandom_range(0, 2);
      buildExpected(wr, addr, len);
      applyStimulus(wr, addr, wdata, len, stall, $sformatf("rand%0d", k));
    end
    for (int i = 0; i < 256; i++) err_tbl[i] = 1'b0;

    // Reset while a read beat is offered and not taken.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h40; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rsprst valid before", 32'(rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rsprst valid", 32'(rsp_valid), 32'd0);
    checkOutput("rsprst rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset in RD_WAIT of a 3-beat burst.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h41; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rdwait issue en", 32'(mc_en), 32'd1);
    @(negedge clk);
    checkOutput("rdwait mc_addr", 32'(mc_addr), 32'h41);
    reset = 1'b0;
    #1;
    checkOutput("rdwait rst ctl", {29'd0, mc_en, rsp_valid, req_ready}, 32'd0);
    checkOutput("rdwait rst addr", 32'(mc_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rdwait release req_ready", 32'(req_ready), 32'd1);
    buildExpected(1'b1, 8'h20, 4'd0);
    applyStimulus(1'b1, 8'h20, 8'hC3, 4'd0, 0, "after_rst_wr");
    buildExpected(1'b0, 8'h20, 4'd0);
    applyStimulus(1'b0, 8'h20, 8'h00, 4'd0, 0, "after_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
